// File: rtl/riscv_tb_stdout.sv
// Stdout sink on the core data bus: decodes the STDOUT window and buffers
// PUSH bytes in a FIFO that drains to the harness on a valid/ready stream.
// Latency: gnt combinational, rvalid 1 cycle after gnt, pushed byte visible
// 1 cycle after gnt.
// Backpressure: a PUSH into a full FIFO is held off (no gnt) until space
// frees up. After STALL_LIMIT cycles it is granted and dropped, and the
// sticky overflow flag is set.
//
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   data_req_i .. data_wdata_i       bus request side
//   data_gnt_o                       grant (combinational)
//   data_rvalid_o, data_rdata_o,
//   data_err_o                       registered response
//   char_valid_o, char_data_o,
//   char_ready_i                     FIFO drain stream
//   line_done_o                      pulse when 0x0A is popped
//   overflow_o                       sticky dropped-character flag
module riscv_tb_stdout #(
    parameter logic [31:0] BASE_ADDR   = 32'h1A10_F000,
    parameter logic [31:0] ADDR_LEN    = 32'h0000_1000,
    parameter int          FIFO_DEPTH  = 16,
    parameter int          STALL_LIMIT = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        char_valid_o,
    output logic [7:0]  char_data_o,
    input  logic        char_ready_i,
    output logic        line_done_o,
    output logic        overflow_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STALL_LIMIT) + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] STALL_MAX = SW'(STALL_LIMIT - 1);

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [SW-1:0] r_stall;
    logic          r_ovf;
    logic          r_rvalid;
    logic          r_err;
    logic [31:0]   r_rdata;

    logic          w_in_win;
    logic [11:0]   w_off;
    logic          w_is_push;
    logic          w_is_stat;
    logic          w_full;
    logic          w_empty;
    logic          w_stall_max;
    logic          w_gnt;
    logic          w_do_push;
    logic          w_drop;
    logic          w_pop;
    logic [7:0]    w_head;
    logic [7:0]    w_cnt8;
    logic [31:0]   w_status;
    logic          w_unused;

    assign w_in_win    = (data_addr_i & ~(ADDR_LEN - 32'd1)) == BASE_ADDR;
    assign w_off       = data_addr_i[11:0];
    assign w_is_push   = w_in_win & data_we_i & (w_off == 12'h000) & data_be_i[0];
    assign w_is_stat   = w_in_win & ~data_we_i & (w_off == 12'h004);
    assign w_full      = (r_count == FULL_CNT);
    assign w_empty     = (r_count == '0);
    assign w_stall_max = (r_stall == STALL_MAX);

    // A PUSH into a full FIFO waits, unless it has waited long enough, in
    // which case it is granted and the byte is thrown away.
    assign w_gnt     = data_req_i & (~w_in_win | ~w_is_push | ~w_full | w_stall_max);
    assign w_do_push = w_gnt & w_is_push & ~w_full;
    assign w_drop    = w_gnt & w_is_push & w_full;
    assign w_pop     = ~w_empty & char_ready_i;

    assign w_head   = r_mem[r_rd_ptr];
    assign w_cnt8   = 8'(r_count);
    assign w_status = {r_ovf, 15'b0, w_cnt8, 6'b0, w_full, w_empty};

    assign w_unused = &{1'b0, data_wdata_i[31:8], data_be_i[3:1]};

    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= data_wdata_i[7:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Counts consecutive cycles a PUSH sits on a full FIFO; any grant or a
    // dropped request restarts it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall <= '0;
        end else if (w_gnt | ~data_req_i) begin
            r_stall <= '0;
        end else if (w_is_push & w_full) begin
            r_stall <= r_stall + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end
    end

    // STATUS is captured from pre-update FIFO state in the granting cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_gnt;
            r_err    <= w_gnt & ~w_in_win;
            r_rdata  <= (w_gnt & w_is_stat) ? w_status : 32'h0;
        end
    end

    assign data_gnt_o    = w_gnt;
    assign data_rvalid_o = r_rvalid;
    assign data_rdata_o  = r_rdata;
    assign data_err_o    = r_err;
    assign char_valid_o  = ~w_empty;
    assign char_data_o   = w_empty ? 8'h00 : w_head;
    assign line_done_o   = w_pop & (w_head == 8'h0A);
    assign overflow_o    = r_ovf;

endmodule

// File: tb/tb_riscv_tb_stdout.sv
// Bench for riscv_tb_stdout: directed scenarios and a random phase, all
// compared cycle by cycle against a queue-based reference of the sink.
// Inputs are driven on the falling edge and outputs are sampled 1 time unit later.
module tb_riscv_tb_stdout;
    localparam logic [31:0] STDOUT = 32'h1A10_F000;
    localparam logic [31:0] STATUS = 32'h1A10_F004;
    localparam logic [31:0] OUTWIN = 32'h1A00_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        data_req_i;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic        char_valid_o;
    logic [7:0]  char_data_o;
    logic        char_ready_i;
    logic        line_done_o;
    logic        overflow_o;

    riscv_tb_stdout dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .data_req_i   (data_req_i),
        .data_addr_i  (data_addr_i),
        .data_we_i    (data_we_i),
        .data_be_i    (data_be_i),
        .data_wdata_i (data_wdata_i),
        .data_gnt_o   (data_gnt_o),
        .data_rvalid_o(data_rvalid_o),
        .data_rdata_o (data_rdata_o),
        .data_err_o   (data_err_o),
        .char_valid_o (char_valid_o),
        .char_data_o  (char_data_o),
        .char_ready_i (char_ready_i),
        .line_done_o  (line_done_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    int ld_seen  = 0;

    // Reference state: the FIFO contents as a queue plus the few flags the
    // sink is defined to expose.
    logic [7:0]  q[$];
    bit          m_ovf;
    int          m_wait;
    bit          m_rv;
    bit          m_err;
    logic [31:0] m_rd;
    bit          m_rd_chk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One bus cycle: drive, compare against the reference, advance it.
    task automatic cyc(input logic req, input logic [31:0] addr, input logic we,
                       input logic [3:0] be, input logic [31:0] wd, input logic rdy,
                       input logic rst, output logic g);
        bit          in_win, push, full, pop, eg, eld;
        logic [31:0] off, stat;
        logic [7:0]  head;
        data_req_i   = req;
        data_addr_i  = addr;
        data_we_i    = we;
        data_be_i    = be;
        data_wdata_i = wd;
        char_ready_i = rdy;
        rst_i        = rst;
        #1;
        in_win = (addr >= STDOUT) && (addr < STDOUT + 32'h1000);
        off    = addr - STDOUT;
        push   = in_win && we && off == 0 && be[0];
        full   = q.size() == 16;
        eg     = req && (!in_win || !push || !full || m_wait == 255);
        head   = (q.size() != 0) ? q[0] : 8'h00;
        pop    = q.size() != 0 && rdy;
        eld    = pop && head == 8'h0A;

        check("gnt", data_gnt_o, eg);
        check("line_done", line_done_o, eld);
        check("char_valid", char_valid_o, q.size() != 0);
        check("char_data", char_data_o, head);
        check("rvalid", data_rvalid_o, m_rv);
        check("overflow", overflow_o, m_ovf);
        if (m_rv || m_rd_chk) begin
            check("err", data_err_o, m_err);
            check("rdata", data_rdata_o, m_rd);
        end
        if (line_done_o === 1'b1) ld_seen++;

        if (rst) begin
            q.delete();
            m_ovf = 0; m_wait = 0; m_rv = 0; m_err = 0; m_rd = 0; m_rd_chk = 1;
        end else begin
            stat = (32'(m_ovf) << 31) | (32'(q.size()) << 8) | (32'(full) << 1)
                 | 32'(q.size() == 0);
            m_rd_chk = 0;
            m_rv  = eg;
            m_err = eg && !in_win;
            m_rd  = (eg && in_win && !we && off == 4) ? stat : 32'h0;
            if (eg && push && full) m_ovf = 1;
            if (pop) void'(q.pop_front());
            if (eg && push && !full) q.push_back(wd[7:0]);
            if (eg || !req) m_wait = 0;
            else if (push && full) m_wait++;
        end
        g = eg;
        @(negedge clk_i);
    endtask

    task automatic idle(input logic rdy, input int n);
        logic g;
        for (int i = 0; i < n; i++) cyc(0, 32'h0, 0, 4'h0, 32'h0, rdy, 0, g);
    endtask

    // Holds the request until granted (bounded). On return the response of
    // the granted cycle is on the bus.
    task automatic bus(input logic [31:0] addr, input logic we, input logic [3:0] be,
                       input logic [31:0] wd, input logic rdy,
                       output int waited, output logic [31:0] rd);
        logic g;
        g = 0;
        waited = 0;
        while (!g && waited < 400) begin
            cyc(1, addr, we, be, wd, rdy, 0, g);
            waited++;
        end
        if (!g) check("bus_timeout", 32'(waited), 32'd0);
        rd = data_rdata_o;
    endtask

    initial begin
        int          w;
        logic [31:0] rd;
        logic        g;
        logic [7:0]  hello[3];
        int          ld0;
        hello[0] = 8'h48; hello[1] = 8'h69; hello[2] = 8'h0A;
        rst_i = 1; data_req_i = 0; data_addr_i = 0; data_we_i = 0;
        data_be_i = 0; data_wdata_i = 0; char_ready_i = 0;
        m_ovf = 0; m_wait = 0; m_rv = 0; m_err = 0; m_rd = 0; m_rd_chk = 0;
        @(negedge clk_i);
        @(negedge clk_i);
        cyc(0, 32'h0, 0, 4'h0, 32'h0, 0, 1, g);
        check("rst_rvalid", data_rvalid_o, 0);
        check("rst_rdata", data_rdata_o, 0);
        check("rst_char_valid", char_valid_o, 0);
        check("rst_char_data", char_data_o, 0);

        // Hello line
        ld0 = ld_seen;
        for (int i = 0; i < 3; i++) begin
            bus(STDOUT, 1, 4'hF, {24'h0, hello[i]}, 1, w, rd);
            check("hello_gnt_wait", 32'(w), 32'd1);
            check("hello_err", data_err_o, 0);
        end
        idle(1, 4);
        check("hello_line_done", 32'(ld_seen - ld0), 32'd1);

        // Fill to full, status, then the held 17th write
        for (int i = 0; i < 16; i++) bus(STDOUT, 1, 4'h1, $urandom, 0, w, rd);
        bus(STATUS, 0, 4'hF, 0, 0, w, rd);
        check("status_full", rd, 32'h0000_1002);
        for (int i = 0; i < 3; i++) cyc(1, STDOUT, 1, 4'h1, $urandom, 0, 0, g);
        cyc(1, STDOUT, 1, 4'h1, 32'h55, 1, 0, g);
        check("full_pop_no_gnt", g, 0);
        bus(STDOUT, 1, 4'h1, 32'h55, 0, w, rd);
        check("gnt_after_pop", 32'(w), 32'd1);

        // Stall limit: FIFO full again, byte dropped after 256 cycles
        bus(STDOUT, 1, 4'h1, 32'hEE, 0, w, rd);
        check("stall_grant_cycle", 32'(w), 32'd256);
        idle(0, 1);
        check("overflow_set", overflow_o, 1);
        bus(STATUS, 0, 4'hF, 0, 0, w, rd);
        check("status_ovf", rd, 32'h8000_1002);
        idle(1, 20);

        // Out-of-window read and write
        bus(OUTWIN, 0, 4'hF, 0, 0, w, rd);
        check("oow_rd_err", data_err_o, 1);
        check("oow_rd_data", rd, 0);
        bus(OUTWIN, 1, 4'h1, 32'h41, 0, w, rd);
        check("oow_wr_err", data_err_o, 1);
        check("oow_wr_wait", 32'(w), 32'd1);
        check("oow_fifo", char_valid_o, 0);

        // Steady push+pop at count 5 across pointer wrap
        for (int i = 0; i < 5; i++) bus(STDOUT, 1, 4'h1, $urandom, 0, w, rd);
        for (int i = 0; i < 40; i++) bus(STDOUT, 1, 4'h1, $urandom, 1, w, rd);
        bus(STATUS, 0, 4'hF, 0, 0, w, rd);
        check("status_cnt5", rd, 32'h8000_0500);
        idle(1, 8);

        // Reset with 8 queued and a response pending
        for (int i = 0; i < 8; i++) bus(STDOUT, 1, 4'h1, $urandom, 0, w, rd);
        cyc(1, STATUS, 0, 4'hF, 0, 0, 1, g);
        check("rst_mid_char_valid", char_valid_o, 0);
        check("rst_mid_rvalid", data_rvalid_o, 0);
        check("rst_mid_ovf", overflow_o, 0);
        bus(STATUS, 0, 4'hF, 0, 0, w, rd);
        check("status_after_rst", rd, 32'h0000_0001);

        // Random traffic
        for (int blk = 0; blk < 12; blk++) begin
            int rdy_pct;
            rdy_pct = (blk % 3 == 0) ? 5 : ((blk % 3 == 1) ? 50 : 95);
            for (int i = 0; i < 250; i++) begin
                logic [31:0] a;
                logic        r, rs;
                case ($urandom_range(0, 5))
                    0, 1, 2: a = STDOUT;
                    3:       a = STATUS;
                    4:       a = STDOUT + {20'h0, 10'($urandom), 2'b00};
                    default: a = OUTWIN + $urandom_range(0, 32'h1F);
                endcase
                rs = ($urandom_range(0, 499) == 0);
                r  = !rs && ($urandom_range(0, 3) != 0);
                cyc(r, a, 1'($urandom), 4'($urandom), $urandom,
                    ($urandom_range(1, 100) <= rdy_pct), rs, g);
            end
        end
        idle(1, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
